// File: rtl/router_nport_if.sv
// Ingress/egress bundle of the N-port packet router.
// The router takes the slave view; whoever feeds packets and drains the ports takes the master view.
interface router_nport_if #(
  parameter int DATA_W  = 8,
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 3
);
  logic                      pkt_valid;
  logic                      pkt_last;
  logic [DATA_W-1:0]         data_in;
  logic [ADDR_W-1:0]         dest_addr;
  logic                      ready_in;
  logic [N_PORTS*DATA_W-1:0] data_out;
  logic [N_PORTS-1:0]        valid_out;
  logic [N_PORTS-1:0]        ready_out;

  modport master (
    output pkt_valid, pkt_last, data_in, dest_addr, ready_out,
    input  ready_in, data_out, valid_out
  );

  modport slave (
    input  pkt_valid, pkt_last, data_in, dest_addr, ready_out,
    output ready_in, data_out, valid_out
  );
endinterface

// File: rtl/router_nport.sv
// 1-to-N multi-beat packet router.
// The destination is taken from a packet's first beat. Every beat goes into a per-output
// show-ahead FIFO, so a stalled sink only holds back traffic headed for its own port.
// Packets addressed past the last port are swallowed and counted in a saturating drop counter.
module router_nport #(
  parameter int DATA_W     = 8,
  parameter int N_PORTS    = 4,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 8
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active low
  router_nport_if.slave     bus,
  output logic [1:0]        state_out,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int DEST_SPAN = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  state_e              state_r;
  logic [ADDR_W-1:0]   cur_dest_r;
  logic [DROP_W-1:0]   drop_cnt_r;

  logic [N_PORTS-1:0]   full_s;
  logic [DEST_SPAN-1:0] full_pad_s;
  logic [N_PORTS-1:0]   valid_s;
  logic [N_PORTS-1:0]   push_s;
  logic [N_PORTS-1:0]   pop_s;
  logic [DATA_W-1:0]    head_s [N_PORTS];
  logic [N_PORTS*DATA_W-1:0] data_out_s;
  logic                 in_range_s;
  logic                 ready_in_s;
  logic                 accept_s;

  // A first beat may name a port that does not exist.
  assign in_range_s = (32'(bus.dest_addr) < 32'(N_PORTS));

  // Widen the full flags to the whole address space so any dest_addr can index them safely.
  always_comb begin
    full_pad_s = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      full_pad_s[i] = full_s[i];
    end
  end

  // Ingress back-pressure: only the registered full flag of the targeted FIFO matters.
  always_comb begin
    ready_in_s = 1'b0;
    if (!rst) begin
      ready_in_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_range_s) begin
            ready_in_s = ~full_pad_s[bus.dest_addr];
          end else begin
            ready_in_s = 1'b1;
          end
        end
        ST_ROUTE: ready_in_s = ~full_pad_s[cur_dest_r];
        ST_DROP:  ready_in_s = 1'b1;
        default:  ready_in_s = 1'b0;
      endcase
    end
  end

  assign accept_s     = bus.pkt_valid & ready_in_s;
  assign bus.ready_in = ready_in_s;

  // Steer an accepted beat to exactly one FIFO, or to none when the packet is being dropped.
  always_comb begin
    push_s = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (accept_s && (state_r == ST_IDLE) && in_range_s && (bus.dest_addr == ADDR_W'(i))) begin
        push_s[i] = 1'b1;
      end else if (accept_s && (state_r == ST_ROUTE) && (cur_dest_r == ADDR_W'(i))) begin
        push_s[i] = 1'b1;
      end else begin
        push_s[i] = 1'b0;
      end
    end
  end

  // Packet framing FSM: latches the destination and counts dropped packets once, on their first beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      cur_dest_r <= '0;
      drop_cnt_r <= '0;
    end else if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if (in_range_s) begin
            cur_dest_r <= bus.dest_addr;
            state_r    <= bus.pkt_last ? ST_IDLE : ST_ROUTE;
          end else begin
            if (drop_cnt_r != {DROP_W{1'b1}}) begin
              drop_cnt_r <= drop_cnt_r + DROP_W'(1);
            end else begin
              drop_cnt_r <= drop_cnt_r;
            end
            state_r <= bus.pkt_last ? ST_IDLE : ST_DROP;
          end
        end
        ST_ROUTE: state_r <= bus.pkt_last ? ST_IDLE : ST_ROUTE;
        ST_DROP:  state_r <= bus.pkt_last ? ST_IDLE : ST_DROP;
        default:  state_r <= ST_IDLE;
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  assign state_out = state_r;
  assign drop_cnt  = drop_cnt_r;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_fifo
    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    assign full_s[g]  = (count_r == CNT_W'(FIFO_DEPTH));
    assign valid_s[g] = (count_r != '0);
    assign pop_s[g]   = valid_s[g] & bus.ready_out[g];
    // Show-ahead head, forced to zero when there is nothing to present.
    assign head_s[g]  = valid_s[g] ? mem_r[rd_ptr_r] : '0;

    // FIFO storage; cleared on reset so no stale beat can ever surface.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k < FIFO_DEPTH; k++) begin
          mem_r[k] <= '0;
        end
      end else if (push_s[g]) begin
        mem_r[wr_ptr_r] <= bus.data_in;
      end else begin
        mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
    end

    // Pointer and occupancy bookkeeping; the pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
        count_r  <= '0;
      end else begin
        if (push_s[g]) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end else begin
          wr_ptr_r <= wr_ptr_r;
        end
        if (pop_s[g]) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end else begin
          rd_ptr_r <= rd_ptr_r;
        end
        case ({push_s[g], pop_s[g]})
          2'b10:   count_r <= count_r + CNT_W'(1);
          2'b01:   count_r <= count_r - CNT_W'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // Pack the per-port heads onto the flat output bus.
  always_comb begin
    data_out_s = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      data_out_s[i*DATA_W +: DATA_W] = head_s[i];
    end
  end

  assign bus.data_out  = data_out_s;
  assign bus.valid_out = valid_s;

endmodule
